// File: rtl/sha3_pkg.sv
// Shared SHA-3 sponge definitions: state width, SHAKE128 rate and the controller FSM encoding.
package sha3_pkg;
  localparam int STATE_W    = 1600;
  localparam int R_SHAKE128 = 1344;

  typedef enum logic [1:0] {
    IDLE,
    PERM_REQ,
    PERM_WAIT,
    SQUEEZE
  } sponge_st_e;
endpackage

// File: rtl/shake128_sponge_ctrl_pad.sv
// Combinational pad10*1 rate-block generator: keeps msg bits below msg_len, then sets bit msg_len and bit R-1.
module shake128_sponge_ctrl_pad #(
  parameter int R     = 1344,
  parameter int MSG_W = 1088
) (
  input  logic [MSG_W-1:0] msg,
  input  logic [10:0]      msg_len,
  output logic [R-1:0]     pad
);
  for (genvar i = 0; i < R; i++) begin : g_bit
    logic m;
    if (i < MSG_W) begin : g_msg
      assign m = msg[i] & (11'(i) < msg_len);
    end else begin : g_nomsg
      assign m = 1'b0;
    end
    if (i == R - 1) begin : g_top
      assign pad[i] = 1'b1;
    end else begin : g_low
      assign pad[i] = m | (11'(i) == msg_len);
    end
  end
endmodule

// File: rtl/shake128_sponge_ctrl.sv
// SHAKE128 single-block sponge sequencer: pad/absorb one message, drive the external permutation, squeeze nb blocks.
module shake128_sponge_ctrl
  import sha3_pkg::*;
#(
  parameter int R     = R_SHAKE128,
  parameter int MSG_W = 1088,
  parameter int NB_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MSG_W-1:0]   msg,
  input  logic [10:0]        msg_len,
  input  logic [NB_W-1:0]    n_blocks,
  output logic               busy,
  output logic               err,
  output logic               perm_start,
  output logic [STATE_W-1:0] perm_state_in,
  input  logic               perm_done,
  input  logic [STATE_W-1:0] perm_state_out,
  output logic [R-1:0]       out_block,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               done
);
  sponge_st_e         st_q, st_d;
  logic [STATE_W-1:0] state_q;
  logic [NB_W-1:0]    nb_q, cnt_q;
  logic [R-1:0]       pad;
  logic               done_q, err_q;
  logic               start_ok, accept, reject, hs, last;

  shake128_sponge_ctrl_pad #(.R(R), .MSG_W(MSG_W)) u_pad (
    .msg     (msg),
    .msg_len (msg_len),
    .pad     (pad)
  );

  // A start landing on the done pulse belongs to the finishing request and is dropped.
  assign start_ok = (st_q == IDLE) && start && !done_q;
  assign accept   = start_ok && (msg_len <= 11'(MSG_W));
  assign reject   = start_ok && !accept;
  assign hs       = (st_q == SQUEEZE) && out_ready;
  assign last     = (cnt_q == nb_q - NB_W'(1));

  always_comb begin
    st_d       = st_q;
    perm_start = 1'b0;
    out_valid  = 1'b0;
    unique case (st_q)
      IDLE:      if (accept) st_d = PERM_REQ;
      PERM_REQ:  begin perm_start = 1'b1; st_d = PERM_WAIT; end
      PERM_WAIT: if (perm_done) st_d = SQUEEZE;
      SQUEEZE: begin
        out_valid = 1'b1;
        if (out_ready) st_d = last ? IDLE : PERM_REQ;
      end
      default:   st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= IDLE;
      state_q <= '0;
      nb_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      done_q <= hs && last;
      err_q  <= reject;
      if (accept) begin
        state_q <= {{(STATE_W-R){1'b0}}, pad};
        nb_q    <= (n_blocks == '0) ? NB_W'(1) : n_blocks;
        cnt_q   <= '0;
      end else if (st_q == PERM_WAIT && perm_done) begin
        state_q <= perm_state_out;
      end
      if (hs && !last) cnt_q <= cnt_q + NB_W'(1);
    end
  end

  assign busy          = (st_q != IDLE);
  assign err           = err_q;
  assign done          = done_q;
  assign perm_state_in = state_q;
  assign out_block     = state_q[R-1:0];
endmodule

// File: tb/tb_shake128_sponge_ctrl.sv
// Scoreboard bench for shake128_sponge_ctrl with a 5-cycle XOR-all-ones permutation stub.
module tb_shake128_sponge_ctrl;
  localparam int R = 1344, MSG_W = 1088, NB_W = 4, SW = 1600, PLAT = 5;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [MSG_W-1:0] msg = '0;
  logic [10:0] msg_len = '0;
  logic [NB_W-1:0] n_blocks = '0;
  logic busy, err, perm_start, perm_done, out_valid, done;
  logic out_ready = 1'b0;
  logic [SW-1:0] perm_state_in, perm_state_out;
  logic [R-1:0] out_block;

  int tests = 0, fails = 0, got_done = 0, got_err = 0;
  logic [R-1:0]  exp_blk[$];
  logic [SW-1:0] exp_pin[$];
  logic spur = 1'b0;
  logic [2:0] pd_cnt;
  logic [SW-1:0] pstate;
  logic hold_q;
  logic [R-1:0] hold_blk;

  always #5 clk = ~clk;

  shake128_sponge_ctrl #(.R(R), .MSG_W(MSG_W), .NB_W(NB_W)) dut (
    .clk(clk), .rst(rst), .start(start), .msg(msg), .msg_len(msg_len), .n_blocks(n_blocks),
    .busy(busy), .err(err), .perm_start(perm_start), .perm_state_in(perm_state_in),
    .perm_done(perm_done), .perm_state_out(perm_state_out), .out_block(out_block),
    .out_valid(out_valid), .out_ready(out_ready), .done(done)
  );

  // permutation stub: done pulse PLAT cycles after perm_start, returns ~state
  always @(posedge clk or posedge rst)
    if (rst) begin pd_cnt <= '0; pstate <= '0; end
    else if (perm_start) begin pd_cnt <= 3'(PLAT); pstate <= perm_state_in; end
    else if (pd_cnt != 0) pd_cnt <= pd_cnt - 3'd1;
  assign perm_done      = (pd_cnt == 3'd1) || spur;
  assign perm_state_out = spur ? {SW/8{8'hA5}} : ~pstate;

  task automatic chk_i(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    tests++;
    if (act !== exp) begin
      int w;
      w = 0;
      fails++;
      for (int i = SW/64-1; i >= 0; i--) if (act[i*64 +: 64] !== exp[i*64 +: 64]) w = i;
      $display("FAIL %s: word %0d act=%h exp=%h", nm, w, act[w*64 +: 64], exp[w*64 +: 64]);
    end
  endtask

  task automatic fail_evt(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: act=event exp=none", nm);
  endtask

  // reference pad straight from the rule: keep msg[0..len-1], set bit len and bit R-1
  function automatic logic [R-1:0] model_pad(input logic [MSG_W-1:0] m, input int len);
    logic [R-1:0] p;
    p = '0;
    for (int i = 0; i < len; i++) p[i] = m[i];
    p[len]   = 1'b1;
    p[R-1]   = 1'b1;
    return p;
  endfunction

  function automatic logic [MSG_W-1:0] rand_msg();
    logic [MSG_W-1:0] m;
    for (int i = 0; i < MSG_W; i += 32) m[i +: 32] = $urandom;
    return m;
  endfunction

  // monitor
  always @(negedge clk)
    if (rst) hold_q <= 1'b0;
    else begin
      if (perm_start) begin
        if (exp_pin.size() == 0) fail_evt("extra_perm_start");
        else chk_w("perm_state_in", perm_state_in, exp_pin.pop_front());
      end
      if (hold_q) begin
        chk_i("bp_valid_held", int'(out_valid), 1);
        chk_w("bp_block_held", SW'(out_block), SW'(hold_blk));
      end
      if (out_valid && out_ready) begin
        if (exp_blk.size() == 0) fail_evt("extra_block");
        else chk_w("out_block", SW'(out_block), SW'(exp_blk.pop_front()));
      end
      hold_q   <= out_valid && !out_ready;
      hold_blk <= out_block;
      if (done) got_done++;
      if (err) got_err++;
    end

  // mode 0: ready always, 1: random ready, 2: 10-cycle backpressure + spurious perm_done
  task automatic run(input logic [MSG_W-1:0] m, input int len, input int nb, input int mode, input bit poke);
    logic [SW-1:0] s;
    int nbe, k, lat, bp, d0;
    bit seen;
    nbe = (nb == 0) ? 1 : nb;
    s = '0;
    s[R-1:0] = model_pad(m, len);
    for (int b = 0; b < nbe; b++) begin
      exp_pin.push_back(s);
      s = ~s;
      exp_blk.push_back(s[R-1:0]);
    end
    d0 = got_done;
    @(posedge clk); #1;
    msg = m; msg_len = 11'(len); n_blocks = NB_W'(nb); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; msg = rand_msg();
    k = 1; seen = 0; lat = 0; bp = 0;
    while (!done && k < 400) begin
      if (out_valid && !seen) begin seen = 1; lat = k; end
      if (k == 1) chk_i("busy_in_op", int'(busy), 1);
      if (poke && k == 3) begin start = 1'b1; msg_len = 11'd3; n_blocks = NB_W'(2); end
      else if (poke && k == 4) start = 1'b0;
      bp = out_valid ? bp + 1 : 0;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom % 2);
        default: out_ready = (bp > 10);
      endcase
      spur = (mode == 2 && bp == 4);
      @(posedge clk); #1;
      k++;
    end
    spur = 1'b0;
    chk_i("first_valid_latency", lat, 2 + PLAT);
    chk_i("done_seen", int'(done), 1);
    // start coincident with done must be ignored
    start = 1'b1; msg_len = 11'd8; n_blocks = NB_W'(1); out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk_i("done_width", int'(done), 0);
    repeat (3) @(posedge clk);
    #1;
    chk_i("busy_after", int'(busy), 0);
    chk_i("done_count", got_done - d0, 1);
    chk_i("blk_queue_empty", exp_blk.size(), 0);
    chk_i("pin_queue_empty", exp_pin.size(), 0);
  endtask

  task automatic reject(input int len);
    int e0;
    e0 = got_err;
    @(posedge clk); #1;
    msg = rand_msg(); msg_len = 11'(len); n_blocks = NB_W'(1); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk_i("err_pulse", int'(err), 1);
    chk_i("busy_on_reject", int'(busy), 0);
    @(posedge clk); #1;
    chk_i("err_width", int'(err), 0);
    repeat (3) @(posedge clk);
    #1;
    chk_i("err_count", got_err - e0, 1);
  endtask

  task automatic reset_mid();
    logic [MSG_W-1:0] m;
    logic [SW-1:0] s;
    int d0, e0;
    m = rand_msg();
    s = '0;
    s[R-1:0] = model_pad(m, 100);
    exp_pin.push_back(s);
    @(posedge clk); #1;
    msg = m; msg_len = 11'd100; n_blocks = NB_W'(2); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    d0 = got_done; e0 = got_err;
    rst = 1'b1;
    #1;
    chk_i("rst_busy", int'(busy), 0);
    chk_i("rst_perm_start", int'(perm_start), 0);
    chk_i("rst_out_valid", int'(out_valid), 0);
    chk_i("rst_done", int'(done), 0);
    chk_i("rst_err", int'(err), 0);
    chk_w("rst_perm_state_in", perm_state_in, '0);
    chk_w("rst_out_block", SW'(out_block), '0);
    exp_pin.delete();
    exp_blk.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk_i("rst_no_done", got_done - d0, 0);
    chk_i("rst_no_err", got_err - e0, 0);
    chk_i("rst_idle", int'(busy), 0);
  endtask

  initial begin
    logic [MSG_W-1:0] m;
    repeat (3) @(posedge clk);
    #1;
    chk_i("reset_busy", int'(busy), 0);
    chk_i("reset_out_valid", int'(out_valid), 0);
    chk_i("reset_perm_start", int'(perm_start), 0);
    chk_i("reset_done", int'(done), 0);
    chk_i("reset_err", int'(err), 0);
    chk_w("reset_state", perm_state_in, '0);
    rst = 1'b0;

    m = '0;
    m[259:256] = 4'hF;
    run(m, 260, 1, 0, 0);                        // basic request
    run(rand_msg(), 260, 3, 0, 0);               // multi-block, ready held high
    run(rand_msg(), 517, 2, 2, 0);               // backpressure + spurious perm_done
    reject(MSG_W + 1);
    reject(2047);
    run(rand_msg(), 0, 1, 0, 1);                 // empty message, start while busy
    run(rand_msg(), MSG_W, 0, 0, 0);             // n_blocks=0, full-width message
    reset_mid();
    run(rand_msg(), 33, 2, 1, 0);                // clean run after reset
    for (int t = 0; t < 8; t++)
      run(rand_msg(), int'($urandom_range(0, MSG_W)), int'($urandom_range(0, 4)),
          int'($urandom_range(0, 2)), 1'($urandom % 2));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
